// File: rtl/jtkcpu_div16_seq.sv
// jtkcpu_div16_seq
// Multi-cycle 16/8 unsigned restoring divider for the KCPU execution unit.
// It has no subtractor of its own. Every trial subtraction is run through
// the shared ALU16 (SUB, op 8'h56), and the ALU is driven only while
// iterating.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cen                 clock enable; all state freezes when low
//   start               request, sampled only in IDLE
//   dividend, divisor   operands, captured on accepted start
//   cc_in               CC value, captured on accepted start
//   alu_op/alu_opnd0/1  drive to ALU16 (zero outside ITER)
//   alu_rslt, alu_cc    ALU16 result and flags (only the borrow bit is used)
//   busy, done          busy from accept through FIN; done high in FIN
//   quot, rem, cc_out   results, held until the next accepted start
module jtkcpu_div16_seq #(
  parameter int CC_C_BIT = 0,
  parameter int CC_V_BIT = 1,
  parameter int CC_Z_BIT = 2,
  parameter int CC_N_BIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  input  logic [7:0]  cc_in,
  output logic [7:0]  alu_op,
  output logic [15:0] alu_opnd0,
  output logic [15:0] alu_opnd1,
  input  logic [15:0] alu_rslt,
  input  logic [7:0]  alu_cc,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [7:0]  rem,
  output logic [7:0]  cc_out
);

  localparam logic [7:0] OP_SUB = 8'h56;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] p, d, q;
  logic [7:0]  dvs, ccr;
  logic [3:0]  cnt;
  logic [15:0] trial, p_nxt, q_nxt;
  logic        borrow;

  // Only the borrow bit of the ALU flags matters here.
  logic unused_ok;
  assign unused_ok = &{1'b0, alu_cc};

  function automatic logic [7:0] mk_cc(input logic [7:0] c, input logic [15:0] qv,
                                       input logic v);
    logic [7:0] r;
    r = c;
    r[CC_Z_BIT] = (qv == 16'h0000);
    r[CC_N_BIT] = qv[15];
    r[CC_C_BIT] = qv[7];
    r[CC_V_BIT] = v;
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    alu_op    = 8'h00;
    alu_opnd0 = 16'h0000;
    alu_opnd1 = 16'h0000;
    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    trial     = {p[14:0], d[15]};
    borrow    = alu_cc[CC_C_BIT];
    p_nxt     = borrow ? trial : alu_rslt;
    q_nxt     = {q[14:0], ~borrow};
    case (state)
      IDLE: if (start) state_nxt = (divisor == 8'h00) ? FIN : ITER;
      ITER: begin
        alu_op    = OP_SUB;
        alu_opnd0 = trial;
        alu_opnd1 = {8'h00, dvs};
        if (cnt == 4'd0) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are written on the edge that enters FIN, so they are already
  // valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= 16'h0000;
      d      <= 16'h0000;
      q      <= 16'h0000;
      dvs    <= 8'h00;
      ccr    <= 8'h00;
      cnt    <= 4'd0;
      quot   <= 16'h0000;
      rem    <= 8'h00;
      cc_out <= 8'h00;
    end else if (cen) begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          p   <= 16'h0000;
          q   <= 16'h0000;
          d   <= dividend;
          dvs <= divisor;
          ccr <= cc_in;
          cnt <= 4'd15;
          if (divisor == 8'h00) begin
            quot   <= 16'hFFFF;
            rem    <= dividend[7:0];
            cc_out <= mk_cc(cc_in, 16'hFFFF, 1'b1);
          end
        end
        ITER: begin
          p   <= p_nxt;
          q   <= q_nxt;
          d   <= {d[14:0], 1'b0};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            quot   <= q_nxt;
            rem    <= p_nxt[7:0];
            cc_out <= mk_cc(ccr, q_nxt, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jtkcpu_div16_seq.md
# jtkcpu_div16_seq

Multi-cycle divide sequencer for the KCPU execution unit. It computes a 16-bit by 8-bit unsigned restoring division and performs every trial subtraction through the shared 16-bit ALU's SUB operation (op 8'h56); it adds no subtractor of its own. It sits between the instruction decoder, which starts it and stalls on `busy`, and the ALU16 operand and op muxes, which it drives while `busy` is high.

## Interface
Parameters:
- CC_C_BIT, 0, carry/borrow position in CC
- CC_V_BIT, 1, overflow position in CC
- CC_Z_BIT, 2, zero position in CC
- CC_N_BIT, 3, negative position in CC

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  clock enable; state advances only on clk edges with cen=1
- start  in  1  division request; sampled only in IDLE
- dividend  in  16  unsigned dividend, captured on accepted start
- divisor  in  8  unsigned divisor, captured on accepted start
- cc_in  in  8  CC register value, captured on accepted start
- alu_op  out  8  op code to ALU16
- alu_opnd0  out  16  ALU16 operand 0 (partial remainder)
- alu_opnd1  out  16  ALU16 operand 1 ({8'h00, divisor})
- alu_rslt  in  16  ALU16 result
- alu_cc  in  8  ALU16 cc_out; only bit CC_C_BIT is used (borrow)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- quot  out  16  quotient, held until the next accepted start
- rem  out  8  remainder, held until the next accepted start
- cc_out  out  8  updated CC, held until the next accepted start

## Operation
- The block has three states: IDLE, ITER and FIN.
- IDLE: if start=1 and cen=1, capture the operands and cc_in. Clear the partial remainder P (16 bits) and the quotient shift register Q. Load the dividend into shift register D and set the iteration counter to 15. If divisor=0, go to FIN with the div0 flag set; otherwise go to ITER.
- ITER, one iteration per cen cycle:
  - alu_opnd0 = {P[14:0], D[15]}; alu_opnd1 = {8'h00, divisor}; alu_op = 8'h56.
  - If alu_cc[CC_C_BIT]=0 (no borrow): P ← alu_rslt and shift 1 into Q.
  - Otherwise: P ← alu_opnd0 and shift 0 into Q.
  - D shifts left by one. The counter decrements; after the iteration at counter 0, go to FIN.
  - P never exceeds 9 bits (P < divisor ≤ 255 before each shift), so a 16-bit ALU path cannot overflow.
- FIN (one cycle): done=1.
  - Normal case: quot ← Q, rem ← P[7:0].
  - Divide by zero: quot ← 16'hFFFF, rem ← dividend[7:0].
  - Then go to IDLE.
- cc_out is cc_in with these bits replaced:
  - Z = (quot==0)
  - N = quot[15]
  - C = quot[7]
  - V = div0
  - All other bits pass through unchanged.
- Outside ITER: alu_op=8'h00 and alu_opnd0/alu_opnd1=16'h0000, so ALU16 produces 0 and the shared ALU is free for other users.
- start while busy is ignored; no queuing.
- cen=0 freezes all state, including the done pulse, which stretches until the next cen=1 edge.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, quot=16'h0000, rem=8'h00, cc_out=8'h00, alu_op=8'h00, alu operands 0, counter 0.
- Release of rst_n is synchronised to clk by the system; the block needs no special release handling.
- Counting cen=1 edges with start accepted at edge 0:
  - busy=1 after edge 0.
  - ITER spans edges 1–16.
  - FIN holds during the cycle after edge 16, with done=1 and results valid.
  - busy=0 and done=0 after edge 17.
  - Total: 17 cycles, start to results.
- Divide by zero: FIN after edge 0, so done=1 and results valid in the next cycle, and busy falls after edge 1.
- busy is high in ITER and FIN.
- start=1 in FIN is ignored; the next start is accepted in IDLE, the cycle after done.
- Reset mid-operation aborts immediately. Outputs return to their reset values and no done pulse is issued.
- ALU path is combinational within one cycle (alu_opnd → alu_rslt/alu_cc); the block registers the result at the same edge.

## Test plan
- dividend=16'h03E8, divisor=8'h07 → after 17 cycles done=1, quot=16'h008E, rem=8'h06, Z=0, N=0, C=1, V=0.
- dividend=16'hFFFF, divisor=8'h01 → quot=16'hFFFF, rem=8'h00, N=1, C=1, Z=0; alu_op=8'h56 on exactly 16 cycles.
- dividend=16'h0005, divisor=8'h09 → quot=16'h0000, rem=8'h05, Z=1; cc_in=8'hF0 → cc_out=8'hF4.
- dividend=16'h1234, divisor=8'h00 → done on the 2nd cycle, quot=16'hFFFF, rem=8'h34, V=1, no SUB cycles issued.
- start pulses at cycles 5 and 17 during a busy division → ignored, result unchanged. cen toggled 1/0 randomly → same result, with done count equal to 17 cen-high cycles.
- rst_n low at iteration 8 → busy=0, quot=0, done never pulses; a fresh start afterwards yields correct results.
